// File: rtl/store_pkg.sv
// Shared encodings for the store path: one-hot size modes, FSM states and
// the mode-to-size decoder used by the lane mask generator.
package store_pkg;

    localparam logic [3:0] MODE_B = 4'b0001;
    localparam logic [3:0] MODE_H = 4'b0010;
    localparam logic [3:0] MODE_W = 4'b0100;
    localparam logic [3:0] MODE_D = 4'b1000;

    typedef enum logic {IDLE, BEAT2} state_t;

    typedef struct packed {
        logic       illegal;
        logic [4:0] size;
    } size_info_t;

    // Modes wider than the datapath are illegal as well as non-one-hot ones.
    function automatic size_info_t mode_to_size(input logic [3:0] mode, input int unsigned lanes);
        size_info_t r;
        r.illegal = 1'b1;
        r.size    = 5'd0;
        case (mode)
            MODE_B:  begin r.illegal = 1'b0; r.size = 5'd1; end
            MODE_H:  begin r.illegal = 1'b0; r.size = 5'd2; end
            MODE_W:  begin r.illegal = 1'b0; r.size = 5'd4; end
            MODE_D:  begin r.illegal = 1'b0; r.size = 5'd8; end
            default: ;
        endcase
        if (32'(r.size) > lanes) begin
            r.illegal = 1'b1;
            r.size    = 5'd0;
        end
        return r;
    endfunction

endpackage

// File: rtl/store_lane_ctrl_lane_mask_gen.sv
// Combinational lane decode: byte-enable mask and lane-aligned data spanning
// two words, plus the crossing / misalignment / illegal-mode flags.
module lane_mask_gen
    import store_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = XLEN / 8,
    parameter int OFF   = $clog2(LANES)
) (
    input  logic [3:0]         mode,
    input  logic [OFF-1:0]     off,
    input  logic [XLEN-1:0]    data,
    output logic [2*LANES-1:0] mask,
    output logic [2*XLEN-1:0]  shifted,
    output logic               illegal,
    output logic               crossing,
    output logic               misaligned
);

    size_info_t          si;
    logic [2*LANES-1:0]  base;
    logic [2*XLEN-1:0]   data_m;

    assign si = mode_to_size(mode, LANES);

    // Bytes above the store size are zeroed so disabled lanes carry 0.
    always_comb begin
        base   = '0;
        data_m = '0;
        for (int i = 0; i < LANES; i++) begin
            if (5'(i) < si.size) begin
                base[i]          = 1'b1;
                data_m[i*8 +: 8] = data[i*8 +: 8];
            end
        end
    end

    assign mask       = base << off;
    assign shifted    = data_m << {off, 3'b000};
    assign illegal    = si.illegal;
    assign crossing   = (32'(off) + 32'(si.size)) > 32'(LANES);
    assign misaligned = (32'(off) & (32'(si.size) - 32'd1)) != 32'd0;

endmodule

// File: rtl/store_lane_ctrl.sv
// Store path to a byte-lane RAM; word-crossing stores take two beats.
// Build option MISALIGN_TRAP_EN traps misaligned stores instead of splitting.
module store_lane_ctrl
    import store_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 16,
    parameter int MODE_W = $clog2(XLEN / 8) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [MODE_W-1:0]                 req_mode,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [XLEN-1:0]                   req_wdata,
    output logic [ADDR_W-$clog2(XLEN/8)-1:0]  ram_addr,
    output logic [XLEN-1:0]                   ram_wdata,
    output logic [XLEN/8-1:0]                 ram_we,
    output logic                              done,
    output logic                              err_mode,
    output logic                              misalign
);

    localparam int LANES = XLEN / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int IW    = ADDR_W - OFF;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Handshake: a request is taken on a rising edge with req_valid && req_ready;
    // req_ready is high exactly in IDLE and upstream holds its request while low.
    state_t              state, state_d;
    logic [IW-1:0]       addr_d, b2_addr, b2_addr_d;
    logic [XLEN-1:0]     wdata_d, b2_wdata, b2_wdata_d;
    logic [LANES-1:0]    we_d, b2_we, b2_we_d;
    logic                done_d, err_d, mis_d;

    logic [3:0]          mode4;
    logic [2*LANES-1:0]  mask;
    logic [2*XLEN-1:0]   shifted;
    logic                illegal, crossing, misaligned;
    logic [IW-1:0]       idx;

    assign mode4 = 4'(req_mode);
    assign idx   = req_addr[ADDR_W-1:OFF];

    lane_mask_gen #(.XLEN(XLEN), .LANES(LANES), .OFF(OFF)) u_mask (
        .mode       (mode4),
        .off        (req_addr[OFF-1:0]),
        .data       (req_wdata),
        .mask       (mask),
        .shifted    (shifted),
        .illegal    (illegal),
        .crossing   (crossing),
        .misaligned (misaligned)
    );

    assign req_ready = (state == IDLE);

    always_comb begin
        state_d    = state;
        addr_d     = ram_addr;
        wdata_d    = '0;
        we_d       = '0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        mis_d      = 1'b0;
        b2_addr_d  = b2_addr;
        b2_we_d    = b2_we;
        b2_wdata_d = b2_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (TRAP && misaligned) begin
                        mis_d = 1'b1;
                    end else begin
                        addr_d  = idx;
                        we_d    = mask[LANES-1:0];
                        wdata_d = shifted[XLEN-1:0];
                        if (crossing) begin
                            state_d    = BEAT2;
                            b2_addr_d  = idx + 1'b1;
                            b2_we_d    = mask[2*LANES-1:LANES];
                            b2_wdata_d = shifted[2*XLEN-1:XLEN];
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
            end
            BEAT2: begin
                addr_d  = b2_addr;
                we_d    = b2_we;
                wdata_d = b2_wdata;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= '0;
            done      <= 1'b0;
            err_mode  <= 1'b0;
            misalign  <= 1'b0;
            b2_addr   <= '0;
            b2_we     <= '0;
            b2_wdata  <= '0;
        end else begin
            state     <= state_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            ram_we    <= we_d;
            done      <= done_d;
            err_mode  <= err_d;
            misalign  <= mis_d;
            b2_addr   <= b2_addr_d;
            b2_we     <= b2_we_d;
            b2_wdata  <= b2_wdata_d;
        end
    end

endmodule

// File: tb/tb_store_lane_ctrl.sv
// Directed + random bench for store_lane_ctrl (XLEN=32, ADDR_W=8) with a byte-level
// reference model feeding an expected-beat queue.
module tb_store_lane_ctrl;

    localparam int EW = 46;  // {ready, addr[5:0], we[3:0], wdata[31:0], done, err, mis}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_mode = '0;
    logic [7:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_we;
    logic        done, err_mode, misalign;

    logic [EW-1:0] exp_q[$];
    logic [5:0]    last_addr = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    store_lane_ctrl #(.XLEN(32), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_mode  (req_mode),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .done      (done),
        .err_mode  (err_mode),
        .misalign  (misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input logic rdy, input logic [5:0] a, input logic [3:0] we,
                                           input logic [31:0] d, input logic dn, input logic er,
                                           input logic ms);
        return {rdy, a, we, d, dn, er, ms};
    endfunction

    // Reference: place each store byte at its absolute byte address.
    task automatic model(input logic [2:0] mode, input logic [7:0] addr, input logic [31:0] data);
        int size;
        int a, w, lane;
        logic [3:0]  we1, we2;
        logic [31:0] d1, d2;
        logic [5:0]  base_w;
        case (mode)
            3'b001:  size = 1;
            3'b010:  size = 2;
            3'b100:  size = 4;
            default: size = 0;
        endcase
        if (size == 0) begin
            exp_q.push_back(pack(1'b1, last_addr, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0));
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if ((int'(addr) % size) != 0) begin
            exp_q.push_back(pack(1'b1, last_addr, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1));
            return;
        end
`endif
        we1 = '0; we2 = '0; d1 = '0; d2 = '0;
        base_w = addr[7:2];
        for (int j = 0; j < size; j++) begin
            a    = int'(addr) + j;
            w    = (a / 4) - int'(addr[7:2]);
            lane = a % 4;
            if (w == 0) begin
                we1[lane] = 1'b1;
                d1[lane*8 +: 8] = data[j*8 +: 8];
            end else begin
                we2[lane] = 1'b1;
                d2[lane*8 +: 8] = data[j*8 +: 8];
            end
        end
        if (we2 == 4'h0) begin
            exp_q.push_back(pack(1'b1, base_w, we1, d1, 1'b1, 1'b0, 1'b0));
            last_addr = base_w;
        end else begin
            exp_q.push_back(pack(1'b0, base_w, we1, d1, 1'b0, 1'b0, 1'b0));
            exp_q.push_back(pack(1'b1, base_w + 6'd1, we2, d2, 1'b1, 1'b0, 1'b0));
            last_addr = base_w + 6'd1;
        end
    endtask

    task automatic check_beat(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_ready"}, 64'(req_ready), 64'(e[45]));
        chk({tag, "_addr"},  64'(ram_addr),  64'(e[44:39]));
        chk({tag, "_we"},    64'(ram_we),    64'(e[38:35]));
        chk({tag, "_wdata"}, 64'(ram_wdata), 64'(e[34:3]));
        chk({tag, "_done"},  64'(done),      64'(e[2]));
        chk({tag, "_err"},   64'(err_mode),  64'(e[1]));
        chk({tag, "_mis"},   64'(misalign),  64'(e[0]));
    endtask

    // Drive one request for a cycle, then check every beat it produces.
    task automatic send(input string tag, input logic [2:0] mode, input logic [7:0] addr,
                        input logic [31:0] data);
        req_valid = 1'b1;
        req_mode  = mode;
        req_addr  = addr;
        req_wdata = data;
        model(mode, addr, data);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_beat({tag, "_b1"});
        while (exp_q.size() != 0) begin
            @(posedge clk); #1;
            check_beat({tag, "_b2"});
        end
    endtask

    task automatic idle_cycle(input string tag);
        exp_q.push_back(pack(1'b1, last_addr, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        check_beat(tag);
    endtask

    initial begin
        logic [2:0] rm;
        // clock / reset
        #12;
        chk("rst_we",    64'(ram_we),    64'h0);
        chk("rst_addr",  64'(ram_addr),  64'h0);
        chk("rst_wdata", 64'(ram_wdata), 64'h0);
        chk("rst_done",  64'(done),      64'h0);
        chk("rst_err",   64'(err_mode),  64'h0);
        chk("rst_mis",   64'(misalign),  64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h1);
        @(posedge clk); #1;

        // directed stores
        send("word_10", 3'b100, 8'h10, 32'hDEADBEEF);
        send("byte_13", 3'b001, 8'h13, 32'h000000AB);
        send("byte_10", 3'b001, 8'h10, 32'hFFFFFFCD);
        idle_cycle("idle_a");
        send("half_0b", 3'b010, 8'h0B, 32'h00001234);
        send("word_fe", 3'b100, 8'hFE, 32'h11223344);
        send("half_06", 3'b010, 8'h06, 32'hAAAA5678);
        send("bad_011", 3'b011, 8'h20, 32'h12345678);
        send("bad_000", 3'b000, 8'h24, 32'h12345678);
        send("byte_ff", 3'b001, 8'hFF, 32'h00000077);
        idle_cycle("idle_b");

        // random stores
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0:       rm = 3'b001;
                1, 2:    rm = 3'b010;
                3, 4, 5: rm = 3'b100;
                6:       rm = 3'b001;
                default: rm = 3'(3'b101 + $urandom_range(0, 2));
            endcase
            send("rand", rm, 8'($urandom_range(0, 255)), $urandom);
        end

        // reset while a split store is in flight
        req_valid = 1'b1;
        req_mode  = 3'b010;
        req_addr  = 8'h0B;
        req_wdata = 32'h00005A5A;
        model(3'b010, 8'h0B, 32'h00005A5A);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_beat("mid_rst_b1");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we_async",   64'(ram_we), 64'h0);
        chk("mid_rst_done_async", 64'(done),   64'h0);
        exp_q.delete();
        last_addr = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_we",    64'(ram_we),    64'h0);
            chk("post_rst_done",  64'(done),      64'h0);
            chk("post_rst_ready", 64'(req_ready), 64'h1);
        end
        send("post_rst_word", 3'b100, 8'h40, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_lane_ctrl.md
Name: store_lane_ctrl

Overview:
Parametrised data-memory store path, successor to the combinational byte-write-enable decoder.
- Accepts one store request per valid/ready handshake: byte address, one-hot size, LSB-justified data.
- Drives a registered word-addressed RAM write port with per-lane write enables and lane-aligned data.
- Sits between the LSU/MEM stage and the byte-lane data RAM. Stores that cross a word boundary are split into two RAM beats.

Parameters:
- XLEN, 32: data width in bits; must be 32 or 64. LANES = XLEN/8; OFF = log2(LANES).
- ADDR_W, 16: byte-address width; ram_addr width is ADDR_W-OFF.
- MODE_W, OFF+1: width of the one-hot size field (bit k = store of 2^k bytes).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request valid
- req_ready  out  1  block can accept a request this cycle
- req_mode  in  MODE_W  one-hot size: 001 byte, 010 half, 100 word (1000 dword when XLEN=64)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- ram_addr  out  ADDR_W-OFF  word index to RAM
- ram_wdata  out  XLEN  lane-aligned write data
- ram_we  out  LANES  per-byte-lane write enable, bit i = byte lane i
- done  out  1  one-cycle pulse on the last beat of a store
- err_mode  out  1  one-cycle pulse: illegal req_mode
- misalign  out  1  one-cycle pulse: misaligned store trapped (macro only; otherwise held 0)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ram_we=0, ram_addr=0, ram_wdata=0, done=0, err_mode=0, misalign=0. req_ready=1 once rst_n is high.
- Accept: req_valid && req_ready at a rising edge. All outputs are registered, so beat 1 appears on the cycle after acceptance (latency 1).
- req_ready = (state==IDLE). Upstream holds its request while ready is low.
- Derived values: size = 2^k for one-hot bit k; off = req_addr[OFF-1:0]; idx = req_addr[ADDR_W-1:OFF].
- Lane mask: m = ((1<<size)-1) << off, computed LANES*2 bits wide.
- Data is shifted left by off*8 within a 2*XLEN window.
- FSM IDLE, non-crossing store (off+size <= LANES): single beat.
  - ram_addr=idx, ram_we=m[LANES-1:0], ram_wdata=shifted[XLEN-1:0], done=1.
  - Stay in IDLE, so back-to-back stores run at 1 per cycle.
- FSM IDLE, crossing store (off+size > LANES): beat 1 as above with done=0.
  - Latch the upper half into beat2 registers; go to BEAT2.
- FSM BEAT2: ram_addr=idx+1 (modulo 2^(ADDR_W-OFF), so it wraps to 0), ram_we=m[2*LANES-1:LANES], ram_wdata=shifted[2*XLEN-1:XLEN], done=1. Return to IDLE.
- Illegal mode (not one-hot, zero, or size > LANES): no write (ram_we=0), err_mode=1 for 1 cycle, stay IDLE.
- Any cycle without a beat: ram_we=0 and done=0. ram_wdata lanes not enabled are driven 0.
- Reset mid-operation: an in-flight BEAT2 is dropped and ram_we deasserts immediately (async).

Optional Feature:
MISALIGN_TRAP_EN
- Defined: a store with off not a multiple of size produces no write; misalign pulses 1 cycle at latency 1; the FSM never enters BEAT2.
- Undefined: misaligned stores are handled as above (single beat within a word, split when crossing); misalign is tied 0.

Decomposition:
- Package store_pkg: mode encodings (MODE_B/H/W/D), the FSM state enum {IDLE, BEAT2}, and a function mode_to_size returning the size or an illegal flag.
- One sub-module, lane_mask_gen: combinational (mode, off) -> 2*LANES mask, plus the shifted data.

Test Plan:
- XLEN=32; word at 0x10, data 0xDEADBEEF -> next cycle ram_addr=0x4, ram_we=1111, ram_wdata=0xDEADBEEF, done=1.
- Byte at 0x13, data 0xAB -> ram_addr=0x4, ram_we=1000, ram_wdata=0xAB000000. Back-to-back byte at 0x10 next cycle -> ram_we=0001.
- Half at 0x0B, data 0x1234:
  - Beat 1: ram_addr=0x2, ram_we=1000, wdata[31:24]=0x34, done=0, req_ready=0.
  - Beat 2: ram_addr=0x3, ram_we=0001, wdata[7:0]=0x12, done=1.
  - With MISALIGN_TRAP_EN: ram_we=0, misalign=1.
- ADDR_W=8; word at 0xFE -> beat 1 ram_addr=0x3F, ram_we=1100; beat 2 ram_addr=0x00, ram_we=0011.
- req_mode=3'b011 -> ram_we=0000, err_mode=1 for one cycle, req_ready stays 1.
- Assert rst_n=0 during BEAT2 -> ram_we=0 without waiting for a clock edge. After release: req_ready=1, no beat-2 write ever issued.
